mem_arbiter: RTL and testbench

Two-port to single-port memory arbiter between the MIPS core's instruction-fetch port and data (load/store) port and one shared single-ported memory with a variable-latency request/acknowledge handshake. Serves one access at a time. Gives data accesses priority, with a streak limit that bounds instruction starvation. Returns read data to the owning port with a one-cycle `ready` pulse, and flags a sticky error when memory fails to acknowledge within a bounded time.

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one shared single-ported memory.
// Data has priority; a streak limit forces an instruction grant, and a bounded ack wait flags err.
module mem_arbiter #(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  // data port
  input  logic        d_req,
  input  logic        d_rd_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  // memory port
  output logic        m_req,
  output logic        m_rd_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // status
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_d_streak_o
);

  // Handshake: a requester holds x_req (with stable address/data) until it sees the
  // one-cycle x_ready pulse; m_req stays high with stable m_* until m_ack or timeout.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [15:0] TMO_LIMIT  = 16'(ACK_TIMEOUT);
  localparam logic [31:0] TMO_DATA   = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  logic        m_req_q, m_req_d;
  logic        m_rd_wr_q, m_rd_wr_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic        err_q, err_d;
  logic [3:0]  streak_q, streak_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic        i_pend, d_pend;
  logic [15:0] tcnt_inc;
  logic        timeout_hit;

  // A port completing this cycle must not win the arbitration at the same edge.
  assign i_pend      = i_req & ~i_ready_q;
  assign d_pend      = d_req & ~d_ready_q;
  assign tcnt_inc    = tcnt_q + 16'd1;
  assign timeout_hit = (TMO_LIMIT != 16'd0) && (tcnt_inc == TMO_LIMIT);

  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_rd_wr_d = m_rd_wr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    err_d     = err_q;
    streak_d  = streak_q;
    tcnt_d    = tcnt_q;
    case (state_q)
      IDLE: begin
        if (i_pend && (!d_pend || streak_q == STREAK_MAX)) begin
          state_d   = GRANT_I;
          m_req_d   = 1'b1;
          m_rd_wr_d = 1'b1;
          m_addr_d  = i_addr;
          streak_d  = 4'd0;
          tcnt_d    = 16'd0;
        end else if (d_pend) begin
          state_d   = GRANT_D;
          m_req_d   = 1'b1;
          m_rd_wr_d = d_rd_wr;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          tcnt_d    = 16'd0;
          if (i_pend && streak_q < STREAK_MAX) streak_d = streak_q + 4'd1;
        end
      end
      GRANT_I, GRANT_D: begin
        if (m_ack || timeout_hit) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          if (!m_ack) err_d = 1'b1;
          if (state_q == GRANT_I) begin
            i_ready_d = 1'b1;
            i_rdata_d = m_ack ? m_rdata : TMO_DATA;
          end else begin
            d_ready_d = 1'b1;
            if (m_rd_wr_q) d_rdata_d = m_ack ? m_rdata : TMO_DATA;
          end
        end else begin
          tcnt_d = tcnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_rd_wr_q <= 1'b1;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      err_q     <= 1'b0;
      streak_q  <= 4'd0;
      tcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_rd_wr_q <= m_rd_wr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      err_q     <= err_d;
      streak_q  <= streak_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign m_req          = m_req_q;
  assign m_rd_wr        = m_rd_wr_q;
  assign m_addr         = m_addr_q;
  assign m_wdata        = m_wdata_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign i_ready        = i_ready_q;
  assign d_ready        = d_ready_q;
  assign err            = err_q;
  assign busy           = (state_q != IDLE);
  assign dbg_state_o    = state_q;
  assign dbg_d_streak_o = streak_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run scored against
// a transaction-rule reference model.
module tb_mem_arbiter;

  localparam int MAX_D = 4;
  localparam int TMO   = 8;
  localparam logic [31:0] I_TAG = 32'h0000_1000;
  localparam logic [31:0] D_TAG = 32'h0000_2000;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        i_req = 1'b0, d_req = 1'b0, d_rd_wr = 1'b1;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_rd_wr, busy, err;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_streak;

  int n_pass = 0;
  int n_total = 0;

  mem_arbiter #(.MAX_D_STREAK(MAX_D), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_req(m_req), .m_rd_wr(m_rd_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .err(err), .dbg_state_o(dbg_state), .dbg_d_streak_o(dbg_streak)
  );

  // memory responder: 0 = bench forces ack, 1 = fixed latency, 2 = random latency, 3 = never acks
  int          mem_mode = 0;
  int          mem_lat = 0;
  int          rnd_lat = 0;
  int          seen = 0;
  logic [31:0] mem_val = '0;
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = '0;

  always @(negedge clk) begin
    if (mem_mode == 0) begin
      m_ack   <= force_ack;
      m_rdata <= force_rdata;
      seen    <= 0;
    end else if (!m_req) begin
      m_ack   <= 1'b0;
      seen    <= 0;
      rnd_lat <= ($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 3));
    end else begin
      if (mem_mode != 3 && seen == ((mem_mode == 2) ? rnd_lat : mem_lat)) begin
        m_ack   <= 1'b1;
        m_rdata <= (mem_mode == 2) ? $urandom : mem_val;
      end else begin
        m_ack   <= 1'b0;
      end
      seen <= seen + 1;
    end
  end

  // reference model: one access at a time, owner 0 = none, 1 = instruction, 2 = data
  int          mdl_owner, mdl_wait;
  logic [3:0]  mdl_streak;
  logic        mdl_rd, mdl_iready, mdl_dready, mdl_err;
  logic [31:0] mdl_addr, mdl_wdata, mdl_irdata, mdl_drdata;
  logic        mdl_iw, mdl_dw;
  assign mdl_iw = i_req && !mdl_iready;
  assign mdl_dw = d_req && !mdl_dready;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdl_owner <= 0; mdl_wait <= 0; mdl_streak <= 4'd0; mdl_rd <= 1'b1;
      mdl_iready <= 1'b0; mdl_dready <= 1'b0; mdl_err <= 1'b0;
      mdl_addr <= '0; mdl_wdata <= '0; mdl_irdata <= '0; mdl_drdata <= '0;
    end else if (mdl_owner == 0) begin
      mdl_iready <= 1'b0;
      mdl_dready <= 1'b0;
      mdl_wait   <= 0;
      if (mdl_iw && (!mdl_dw || mdl_streak == 4'(MAX_D))) begin
        mdl_owner <= 1; mdl_addr <= i_addr; mdl_rd <= 1'b1; mdl_streak <= 4'd0;
      end else if (mdl_dw) begin
        mdl_owner <= 2; mdl_addr <= d_addr; mdl_rd <= d_rd_wr; mdl_wdata <= d_wdata;
        if (mdl_iw) mdl_streak <= (mdl_streak >= 4'(MAX_D)) ? 4'(MAX_D) : mdl_streak + 4'd1;
      end
    end else if (m_ack || (TMO != 0 && mdl_wait + 1 == TMO)) begin
      mdl_owner <= 0;
      if (!m_ack) mdl_err <= 1'b1;
      if (mdl_owner == 1) begin
        mdl_iready <= 1'b1;
        mdl_irdata <= m_ack ? m_rdata : 32'hDEADBEEF;
      end else begin
        mdl_dready <= 1'b1;
        if (mdl_rd) mdl_drdata <= m_ack ? m_rdata : 32'hDEADBEEF;
      end
    end else begin
      mdl_wait <= mdl_wait + 1;
    end
  end

  // scoreboard queue of expected grant addresses
  logic [31:0] exp_q[$];

  // driver tasks
  task automatic do_reset();
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; force_ack = 1'b0; mem_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (m_req !== 1'b0) $display("FAIL rst_m_req got %0b want 0", m_req); else n_pass++;
    n_total++; if (m_rd_wr !== 1'b1) $display("FAIL rst_m_rd_wr got %0b want 1", m_rd_wr); else n_pass++;
    n_total++; if (m_addr !== 32'd0 || m_wdata !== 32'd0) $display("FAIL rst_m_addr_wdata got %h/%h want 0/0", m_addr, m_wdata); else n_pass++;
    n_total++; if (i_rdata !== 32'd0 || d_rdata !== 32'd0) $display("FAIL rst_rdata got %h/%h want 0/0", i_rdata, d_rdata); else n_pass++;
    n_total++; if (i_ready !== 1'b0 || d_ready !== 1'b0) $display("FAIL rst_ready got %0b/%0b want 0/0", i_ready, d_ready); else n_pass++;
    n_total++; if (busy !== 1'b0 || err !== 1'b0) $display("FAIL rst_busy_err got %0b/%0b want 0/0", busy, err); else n_pass++;
    n_total++; if (dbg_state !== 2'd0 || dbg_streak !== 4'd0) $display("FAIL rst_state_streak got %0d/%0d want 0/0", dbg_state, dbg_streak); else n_pass++;
  endtask

  task automatic test_instr_read();
    int mreq_cnt = 0, ip = 0, dp = 0, bad = 0;
    logic first = 1'b0;
    logic [31:0] got = '0;
    mem_mode = 1; mem_lat = 2; mem_val = 32'h24080005;
    @(negedge clk);
    i_addr = 32'h0040_0000; i_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) first = m_req;
      if (m_req) begin
        mreq_cnt++;
        if (m_addr !== 32'h0040_0000 || m_rd_wr !== 1'b1) bad++;
      end
      if (i_ready) begin ip++; got = i_rdata; i_req = 1'b0; end
      if (d_ready) dp++;
    end
    n_total++; if (first !== 1'b1) $display("FAIL ird_latency m_req got %0b want 1", first); else n_pass++;
    n_total++; if (mreq_cnt != 3) $display("FAIL ird_mreq_cycles got %0d want 3", mreq_cnt); else n_pass++;
    n_total++; if (ip != 1) $display("FAIL ird_ready_pulses got %0d want 1", ip); else n_pass++;
    n_total++; if (got !== 32'h24080005) $display("FAIL ird_rdata got %h want 24080005", got); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL ird_m_addr bad cycles got %0d want 0", bad); else n_pass++;
    n_total++; if (dp != 0 || d_rdata !== 32'd0) $display("FAIL ird_d_untouched got %0d/%h want 0/0", dp, d_rdata); else n_pass++;
  endtask

  task automatic test_data_write();
    int mreq_cnt = 0, dp = 0, ip = 0, bad = 0;
    logic [31:0] got = '0;
    mem_mode = 1; mem_lat = 1; mem_val = 32'h13572468;
    @(negedge clk);
    d_addr = 32'h1001_0000; d_rd_wr = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 20 && d_req; c++) begin
      @(negedge clk);
      if (d_ready) begin got = d_rdata; d_req = 1'b0; end
    end
    n_total++; if (got !== 32'h13572468) $display("FAIL dwr_prior_read got %h want 13572468", got); else n_pass++;
    d_addr = 32'h1001_0004; d_wdata = 32'hCAFEF00D; d_rd_wr = 1'b0; d_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_req) begin
        mreq_cnt++;
        if (m_rd_wr !== 1'b0 || m_addr !== 32'h1001_0004 || m_wdata !== 32'hCAFEF00D) bad++;
      end
      if (d_ready) begin dp++; d_req = 1'b0; end
      if (i_ready) ip++;
    end
    d_rd_wr = 1'b1;
    n_total++; if (bad != 0) $display("FAIL dwr_m_fields bad cycles got %0d want 0", bad); else n_pass++;
    n_total++; if (mreq_cnt != 2) $display("FAIL dwr_mreq_cycles got %0d want 2", mreq_cnt); else n_pass++;
    n_total++; if (dp != 1 || ip != 0) $display("FAIL dwr_pulses got d%0d/i%0d want d1/i0", dp, ip); else n_pass++;
    n_total++; if (d_rdata !== 32'h13572468) $display("FAIL dwr_rdata_kept got %h want 13572468", d_rdata); else n_pass++;
  endtask

  task automatic test_spurious_ack();
    int bad_busy = 0, bad_ready = 0, bad_data = 0;
    logic [31:0] ir0, dr0;
    mem_mode = 0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    ir0 = i_rdata; dr0 = d_rdata;
    force_ack = 1'b1; force_rdata = 32'hFFFF_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy || m_req || dbg_state != 2'd0) bad_busy++;
      if (i_ready || d_ready) bad_ready++;
      if (i_rdata !== ir0 || d_rdata !== dr0) bad_data++;
    end
    force_ack = 1'b0;
    n_total++; if (bad_busy != 0) $display("FAIL spur_state got %0d bad cycles want 0", bad_busy); else n_pass++;
    n_total++; if (bad_ready != 0) $display("FAIL spur_ready got %0d bad cycles want 0", bad_ready); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL spur_rdata got %0d bad cycles want 0", bad_data); else n_pass++;
  endtask

  task automatic test_streak();
    int grants = 0, own = 0;
    logic prev_mreq = 1'b0, prev_ir = 1'b0, prev_dr = 1'b0;
    logic [31:0] want;
    do_reset();
    mem_mode = 1; mem_lat = 0; mem_val = 32'h0;
    exp_q.delete();
    for (int k = 0; k < 11; k++) exp_q.push_back((k == 4 || k == 10) ? I_TAG : D_TAG);
    i_addr = I_TAG; d_addr = D_TAG; d_rd_wr = 1'b1;
    i_req = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 200 && grants < 11; c++) begin
      @(negedge clk);
      if (m_req && !prev_mreq) begin
        if ((m_addr === I_TAG && prev_ir) || (m_addr === D_TAG && prev_dr)) own++;
        want = exp_q.pop_front();
        n_total++; if (m_addr !== want) $display("FAIL streak_grant%0d got %h want %h", grants, m_addr, want); else n_pass++;
        if (grants == 3) begin
          n_total++; if (dbg_streak !== 4'd4) $display("FAIL streak_sat got %0d want 4", dbg_streak); else n_pass++;
        end
        grants++;
      end
      prev_mreq = m_req; prev_ir = i_ready; prev_dr = d_ready;
      i_req = !d_ready;
    end
    n_total++; if (grants != 11) $display("FAIL streak_grant_count got %0d want 11", grants); else n_pass++;
    n_total++; if (own != 0) $display("FAIL streak_own_ready_grant got %0d want 0", own); else n_pass++;
    n_total++; if (dbg_streak !== 4'd0) $display("FAIL streak_clear got %0d want 0", dbg_streak); else n_pass++;
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int mreq_cnt = 0, dp = 0;
    logic [31:0] got = '0, igot = '0;
    logic e = 1'b0;
    do_reset();
    mem_mode = 3;
    d_addr = 32'h1001_0008; d_rd_wr = 1'b1; d_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_req) mreq_cnt++;
      if (d_ready) begin dp++; got = d_rdata; e = err; d_req = 1'b0; end
    end
    n_total++; if (mreq_cnt != TMO) $display("FAIL tmo_mreq_cycles got %0d want %0d", mreq_cnt, TMO); else n_pass++;
    n_total++; if (dp != 1) $display("FAIL tmo_ready_pulses got %0d want 1", dp); else n_pass++;
    n_total++; if (got !== 32'hDEADBEEF) $display("FAIL tmo_rdata got %h want deadbeef", got); else n_pass++;
    n_total++; if (e !== 1'b1) $display("FAIL tmo_err got %0b want 1", e); else n_pass++;
    mem_mode = 1; mem_lat = 1; mem_val = 32'h0BADF00D;
    i_addr = 32'h0040_0004; i_req = 1'b1;
    for (int c = 0; c < 20 && i_req; c++) begin
      @(negedge clk);
      if (i_ready) begin igot = i_rdata; i_req = 1'b0; end
    end
    @(negedge clk);
    n_total++; if (igot !== 32'h0BADF00D) $display("FAIL tmo_next_read got %h want 0badf00d", igot); else n_pass++;
    n_total++; if (err !== 1'b1) $display("FAIL tmo_err_sticky got %0b want 1", err); else n_pass++;
  endtask

  task automatic test_reset_mid_grant();
    int ip = 0, dp = 0;
    logic [31:0] got = '0;
    mem_mode = 3;
    @(negedge clk);
    d_addr = 32'h1001_0010; d_rd_wr = 1'b1; d_req = 1'b1;
    @(negedge clk);
    n_total++; if (m_req !== 1'b1 || busy !== 1'b1) $display("FAIL rmg_in_grant got %0b/%0b want 1/1", m_req, busy); else n_pass++;
    @(posedge clk);
    #2 reset = 1'b0; d_req = 1'b0;
    #1;
    n_total++; if (m_req !== 1'b0 || busy !== 1'b0) $display("FAIL rmg_async got %0b/%0b want 0/0", m_req, busy); else n_pass++;
    n_total++; if (d_ready !== 1'b0 || err !== 1'b0) $display("FAIL rmg_ready_err got %0b/%0b want 0/0", d_ready, err); else n_pass++;
    @(negedge clk);
    if (d_ready) dp++;
    reset = 1'b1;
    mem_mode = 1; mem_lat = 0; mem_val = 32'h8C820000;
    i_addr = 32'h0040_0008; i_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i_ready) begin ip++; got = i_rdata; i_req = 1'b0; end
      if (d_ready) dp++;
    end
    n_total++; if (ip != 1 || got !== 32'h8C820000) $display("FAIL rmg_next_read got %0d/%h want 1/8c820000", ip, got); else n_pass++;
    n_total++; if (dp != 0) $display("FAIL rmg_no_d_pulse got %0d want 0", dp); else n_pass++;
    n_total++; if (dbg_streak !== 4'd0) $display("FAIL rmg_streak got %0d want 0", dbg_streak); else n_pass++;
  endtask

  task automatic test_random();
    logic own_vld;
    do_reset();
    mem_mode = 2;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      own_vld = (mdl_owner != 0);
      n_total++; if (m_req !== own_vld || busy !== own_vld) $display("FAIL rnd_m_req_busy c=%0d got %0b/%0b want %0b", c, m_req, busy, own_vld); else n_pass++;
      n_total++; if (i_ready !== mdl_iready || d_ready !== mdl_dready) $display("FAIL rnd_ready c=%0d got %0b%0b want %0b%0b", c, i_ready, d_ready, mdl_iready, mdl_dready); else n_pass++;
      n_total++; if (i_rdata !== mdl_irdata) $display("FAIL rnd_i_rdata c=%0d got %h want %h", c, i_rdata, mdl_irdata); else n_pass++;
      n_total++; if (d_rdata !== mdl_drdata) $display("FAIL rnd_d_rdata c=%0d got %h want %h", c, d_rdata, mdl_drdata); else n_pass++;
      n_total++; if (err !== mdl_err || dbg_streak !== mdl_streak) $display("FAIL rnd_err_streak c=%0d got %0b/%0d want %0b/%0d", c, err, dbg_streak, mdl_err, mdl_streak); else n_pass++;
      if (own_vld) begin
        n_total++; if (m_addr !== mdl_addr || m_rd_wr !== mdl_rd) $display("FAIL rnd_m_addr c=%0d got %h/%0b want %h/%0b", c, m_addr, m_rd_wr, mdl_addr, mdl_rd); else n_pass++;
      end
      if (mdl_owner == 2 && !mdl_rd) begin
        n_total++; if (m_wdata !== mdl_wdata) $display("FAIL rnd_m_wdata c=%0d got %h want %h", c, m_wdata, mdl_wdata); else n_pass++;
      end
      if (!i_req || i_ready) begin
        i_req = ($urandom_range(0, 2) == 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || d_ready) begin
        d_req = ($urandom_range(0, 2) == 0);
        d_addr = $urandom & 32'hFFFF_FFFC;
        d_wdata = $urandom;
        d_rd_wr = $urandom_range(0, 1) == 1;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_instr_read();
    test_data_write();
    test_spurious_ack();
    test_streak();
    test_timeout();
    test_reset_mid_grant();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
